// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter that sequences safe writes into a shared bank of transparent latches:
// data settles with the gate closed, one gate opens for GATE_CYCLES, then it closes with data held.
module latch_bank_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_LATCH   = 4,
    parameter int AW          = 2,
    parameter int GATE_CYCLES = 2,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*AW-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           latch_d,
    output logic [NUM_LATCH-1:0]        latch_g,
    output logic [IW-1:0]               grant_id,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    state_t               state_q;
    logic [AW-1:0]        addr_q;
    logic [DATA_W-1:0]    latch_d_q;
    logic [NUM_LATCH-1:0] latch_g_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [IW-1:0]        grant_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        ptr_d;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;

    logic                 win_vld;
    logic [IW-1:0]        win_idx;
    int                   k;

    // Search starts at the requester just after the last grant, wrapping around.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        k       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr_q) + i) % NUM_REQ;
            if (!win_vld && req[k]) begin
                win_vld = 1'b1;
                win_idx = IW'(k);
            end
        end
        ptr_d = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            latch_d_q <= '0;
            latch_g_q <= '0;
            ack_q     <= '0;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (win_vld) begin
                        addr_q    <= req_addr[int'(win_idx)*AW +: AW];
                        latch_d_q <= req_data[int'(win_idx)*DATA_W +: DATA_W];
                        grant_q   <= win_idx;
                        ptr_q     <= ptr_d;
                        busy_q    <= 1'b1;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    latch_g_q <= NUM_LATCH'(1) << addr_q;
                    cnt_q     <= '0;
                    state_q   <= OPEN;
                end
                OPEN: begin
                    if (cnt_q == CW'(GATE_CYCLES - 1)) begin
                        latch_g_q <= '0;
                        ack_q     <= NUM_REQ'(1) << grant_q;
                        state_q   <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                HOLD: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack      = ack_q;
    assign latch_d  = latch_d_q;
    assign latch_g  = latch_g_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter with a behavioural latch bank model.
module tb_latch_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  latch_d;
    logic [3:0]  latch_g;
    logic [1:0]  grant_id;
    logic        busy;

    logic [7:0]  lat [4];
    int          n_cmp;
    int          n_err;

    latch_bank_arbiter #(
        .NUM_REQ(4), .DATA_W(8), .NUM_LATCH(4), .AW(2), .GATE_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .latch_d(latch_d), .latch_g(latch_g), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int j = 0; j < 4; j++)
            if (latch_g[j]) lat[j] = latch_d;
        chk("gate_onehot", 32'($countones(latch_g) <= 1), 32'd1);
        chk("gate_ack_excl", 32'((|latch_g) && (|ack)), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic txn(input int id, input int a, input logic [7:0] d, input bit last);
        step();
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("d_setup", 32'(latch_d), 32'(d));
        chk("g_setup", 32'(latch_g), 32'd0);
        chk("busy_on", 32'(busy), 32'd1);
        step();
        chk("g_open1", 32'(latch_g), 32'(1) << a);
        chk("ack_early", 32'(ack), 32'd0);
        step();
        chk("g_open2", 32'(latch_g), 32'(1) << a);
        step();
        chk("ack", 32'(ack), 32'(1) << id);
        chk("g_hold", 32'(latch_g), 32'd0);
        chk("d_hold", 32'(latch_d), 32'(d));
        if (last) req = '0;
        step();
        chk("ack_off", 32'(ack), 32'd0);
        chk("busy_off", 32'(busy), 32'd0);
        chk("latch_q", 32'(lat[a]), 32'(d));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int j = 0; j < 4; j++) lat[j] = 8'h00;
        req_addr = '0;
        req_data = '0;

        // Reset state
        do_reset();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_g", 32'(latch_g), 32'd0);
        chk("rst_d", 32'(latch_d), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Single write from requester 1 to entry 2
        req_addr[3:2]  = 2'd2;
        req_data[15:8] = 8'hA5;
        req = 4'b0010;
        txn(1, 2, 8'hA5, 1);
        step();
        chk("d_persist", 32'(latch_d), 32'hA5);

        // All four requesting: round-robin from a fresh pointer
        do_reset();
        req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req = 4'b1111;
        txn(0, 0, 8'h10, 0);
        txn(1, 1, 8'h11, 0);
        txn(2, 2, 8'h12, 0);
        txn(3, 3, 8'h13, 0);
        txn(0, 0, 8'h10, 1);

        // Requester 2: inputs change after grant, req dropped during OPEN
        req_addr[5:4]   = 2'd1;
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        step();
        chk("r2_gid", 32'(grant_id), 32'd2);
        chk("r2_d", 32'(latch_d), 32'h3C);
        req_data[23:16] = 8'hFF;
        req_addr[5:4]   = 2'd3;
        step();
        chk("r2_g1", 32'(latch_g), 32'b0010);
        req = 4'b0000;
        step();
        chk("r2_g2", 32'(latch_g), 32'b0010);
        chk("r2_d_frozen", 32'(latch_d), 32'h3C);
        step();
        chk("r2_ack", 32'(ack), 32'b0100);
        step();
        chk("r2_lat1", 32'(lat[1]), 32'h3C);
        chk("r2_lat3", 32'(lat[3]), 32'h13);

        // Asynchronous reset during OPEN, then regrant
        req_addr[1:0] = 2'd3;
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        step();
        chk("ar_gid", 32'(grant_id), 32'd0);
        step();
        chk("ar_open", 32'(latch_g), 32'b1000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_g_async", 32'(latch_g), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("ar_no_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        txn(0, 3, 8'h55, 1);

        // Back-to-back from requester 0 with requester 3 pending
        do_reset();
        req_addr = {2'd2, 2'd0, 2'd0, 2'd0};
        req_data = {8'h99, 8'h00, 8'h00, 8'h11};
        req = 4'b1001;
        txn(0, 0, 8'h11, 0);
        req_data[7:0] = 8'h22;
        txn(3, 2, 8'h99, 0);
        txn(0, 0, 8'h22, 1);
        chk("b2b_lat0", 32'(lat[0]), 32'h22);
        chk("b2b_lat2", 32'(lat[2]), 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
